alu_seq: RTL and testbench
==========================

# alu_seq

Clocked, parametrised successor to the 3-bit opcode ALU. It accepts one operation per handshake, executes single-cycle ops in one clock and multiplies iteratively (shift-add, one bit per clock), then presents a registered result with a one-cycle `done` strobe. It sits between the lab-board input logic (switch operands and opcode, `execute` button pulse) and the display/result register.

## Interface
Parameters:
- `W`, default 3: operand width in bits. Legal range is 2 to 16.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `execute`  in  1  request. Sampled only when `ready`=1.
- `opcodein`  in  3  operation select.
- `a`  in  W  operand A, unsigned.
- `b`  in  W  operand B, unsigned.
- `ready`  out  1  idle, can accept a request.
- `done`  out  1  one-cycle strobe: `f` was just updated.
- `f`  out  2W  registered result. Holds until the next completion.

## Operation
- Opcodes:
  - 000 NOTHING: result 0.
  - 001 ADD.
  - 010 SUB.
  - 011 MUL.
  - 100 SHR.
  - 101 SHL.
  - 110 XNOR.
  - 111 SGT.
- Accept: a request is accepted on a rising edge where `execute`=1 and `ready`=1. `opcodein`, `a` and `b` are captured on that edge. Requests while `ready`=0 are dropped, with no queueing.
- Arithmetic: operands are zero-extended to 2W bits before the operation.
  - ADD: a+b.
  - SUB: (a−b) mod 2^(2W), so a<b gives the two's-complement pattern.
  - SHR: a>>b.
  - SHL: (a<<b) truncated to 2W bits. The result is 0 when b≥2W.
  - XNOR: bitwise W-bit a~^b, zero-extended.
  - SGT: unsigned compare. 1 if a>b, else 0.
  - MUL: full 2W-bit product, never truncated.
- FSM states:
  - IDLE: `ready`=1.
    - Non-MUL accepted: result written to `f`, `done` pulses, stay in IDLE.
    - MUL accepted: load multiplicand, multiplier and accumulator=0, count=0, go to MULT.
  - MULT: `ready`=0.
    - Each edge: if multiplier LSB=1, add the shifted multiplicand to the accumulator. Then shift and increment the count.
    - On the W-th MULT edge: write the accumulator result to `f`, pulse `done`, return to IDLE.
- `done` is high for exactly one cycle per completed operation. The result is never updated without `done`.
- Back-to-back: a single-cycle op may be accepted on every edge. A new request may be accepted on the edge immediately after a MUL completes.

## Timing
- Reset values: `f`=0, `done`=0, `ready`=1. FSM in IDLE, count=0.
- Latency, counted in edges from the accepting edge, with `f` and `done` visible after the edge:
  - Single-cycle ops: 1 edge. The result is visible in the cycle after accept.
  - MUL: W+1 edges. `ready` is low for W cycles.
- Reset mid-MULT: aborts immediately. `f`=0, no `done`, `ready`=1.
- `execute` held high: re-accepts on every edge while `ready`=1. Button debounce and single-pulsing are upstream's job.
- Inputs may change freely after the accepting edge, because the operands are captured.

## Configuration
- `ALU_SEQ_MUL_EN`:
  - Defined: iterative multiplier and MULT state are built as described above.
  - Undefined: no multiplier logic is built. MUL behaves as NOTHING: 1-edge latency, `f`=0, `done` pulses, `ready` never drops.

## Structure
- Package `alu_pkg` holds:
  - the opcode localparams (`OP_NOTHING` … `OP_SGT`, 3-bit);
  - the FSM state encoding (`S_IDLE`, `S_MULT`).
- One sub-module: `alu_mul_iter`.
  - Parametrised by W.
  - Contains the shift-add datapath and the iteration counter.
  - Ports: `clk`, `rst`, `start`, `a`, `b`, `busy`, `last`, `product`.
  - Instantiated only under `ALU_SEQ_MUL_EN`.

## Test plan
All scenarios use W=3, so `f` is 6 bits.
- Reset: assert `rst` asynchronously mid-cycle → `f`=0, `done`=0, `ready`=1 immediately.
- ADD 5+6: one-edge `execute` → the next cycle has `f`=11 and `done`=1 for exactly 1 cycle.
- SUB 2−5 → `f`=6'b111101 (61).
- SGT 3,4 → `f`=0. SGT 4,3 → `f`=1.
- SHL 5,3 → `f`=40. SHL 5,6 → `f`=0. SHR 6,1 → `f`=3.
- MUL 7×7:
  - `ready` is low for 3 cycles.
  - `done` pulses after the 4th edge with `f`=49.
  - An ADD 1+1 presented during MULT is ignored: `f` stays 49, with no extra `done`.
- Reset mid-MUL: assert `rst` on the 2nd MULT cycle → `f`=0, `ready`=1, no `done`.
  - Then MUL 6×5 → `f`=30.
- Without `ALU_SEQ_MUL_EN`: MUL 7×7 → after 1 edge `f`=0, `done`=1, and `ready` stays high.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by alu_seq and its
// iterative multiplier.
package alu_pkg;

    localparam logic [2:0] OP_NOTHING = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_MUL     = 3'b011;
    localparam logic [2:0] OP_SHR     = 3'b100;
    localparam logic [2:0] OP_SHL     = 3'b101;
    localparam logic [2:0] OP_XNOR    = 3'b110;
    localparam logic [2:0] OP_SGT     = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MULT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier, one multiplier bit per clock.
// `start` loads the operands; `last` is high during the W-th step, and
// `product` then already includes that step's partial product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           last,
    output logic [2*W-1:0] product
);

    localparam int unsigned CW = $clog2(W);

    logic           busy_q,   busy_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [2*W-1:0] mcand_q,  mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q,    acc_d;
    logic [2*W-1:0] acc_step;

    // Next-state for one shift-add step, or operand load on start.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = busy_q && (cnt_q == CW'(W - 1));
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Datapath and iteration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Single-cycle ops complete on the
// accepting edge; MUL iterates for W further edges. `f` is registered and
// only changes together with the one-cycle `done` strobe.
// Build option: define ALU_SEQ_MUL_EN to include the iterative multiplier;
// without it MUL behaves as NOTHING.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           execute,
    input  logic [2:0]     opcodein,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*W-1:0] f
);

    state_e         state_q, state_d;
    logic [2*W-1:0] f_q, f_d;
    logic           done_q, done_d;
    logic [2*W-1:0] ax, bx;
    logic [2*W-1:0] alu_res;

`ifdef ALU_SEQ_MUL_EN
    logic           mul_start;
    logic           mul_busy;
    logic           mul_last;
    logic [2*W-1:0] mul_product;

    alu_mul_iter #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );

    assign ready = (state_q == S_IDLE) && !mul_busy;
`else
    assign ready = (state_q == S_IDLE);
`endif

    // Single-cycle result on zero-extended operands; MUL handled elsewhere.
    always_comb begin
        ax      = {{W{1'b0}}, a};
        bx      = {{W{1'b0}}, b};
        alu_res = '0;
        case (opcodein)
            OP_ADD:  alu_res = ax + bx;
            OP_SUB:  alu_res = ax - bx;
            OP_SHR:  alu_res = ax >> b;
            OP_SHL:  alu_res = (32'(b) >= 2 * W) ? '0 : (ax << b);
            OP_XNOR: alu_res = {{W{1'b0}}, a ~^ b};
            OP_SGT:  alu_res = {{(2*W-1){1'b0}}, (a > b)};
            default: alu_res = '0;
        endcase
    end

    // Accept/complete control: next state, result and done strobe.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (execute && ready) begin
`ifdef ALU_SEQ_MUL_EN
                    if (opcodein == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MULT;
                    end else begin
                        f_d    = alu_res;
                        done_d = 1'b1;
                    end
`else
                    f_d    = alu_res;
                    done_d = 1'b1;
`endif
                end
            end
            S_MULT: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_last) begin
                    f_d     = mul_product;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, result and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            done_q  <= done_d;
        end
    end

    assign f    = f_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with W=3. The driver predicts
// each accepted operation's result and completion cycle; the monitor checks
// every done strobe against the queue and that f holds between strobes.
module tb_alu_seq;

    localparam int unsigned W  = 3;
    localparam int unsigned FW = 2 * W;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          execute = 1'b0;
    logic [2:0]    opcodein = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready;
    logic          done;
    logic [FW-1:0] f;

    alu_seq #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .execute  (execute),
        .opcodein (opcodein),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .f        (f)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int unsigned due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    int unsigned model_f = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference results from plain integer arithmetic on the operand values.
    function automatic int unsigned ref_f(logic [2:0] op, int unsigned x, int unsigned y);
        int unsigned m = 1 << FW;
        int unsigned r;
        case (op)
            3'd1:    r = (x + y) % m;
            3'd2:    r = (x + m - y) % m;
            3'd3:    r = MUL_EN ? x * y : 0;
            3'd4:    r = x >> y;
            3'd5:    r = (y >= FW) ? 0 : (x << y) % m;
            3'd6:    r = ~(x ^ y) & ((1 << W) - 1);
            3'd7:    r = (x > y) ? 1 : 0;
            default: r = 0;
        endcase
        return r;
    endfunction

    // One clock of stimulus, driven just after the falling edge.
    task automatic cycle(input bit ex, input logic [2:0] op,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        check("ready", 32'(ready), (busy_cnt == 0) ? 1 : 0);
        execute  = ex;
        opcodein = op;
        a        = x;
        b        = y;
        if (busy_cnt > 0) begin
            busy_cnt--;
        end else if (ex) begin
            e.val  = ref_f(op, 32'(x), 32'(y));
            e.name = nm;
            if (op == 3'd3 && MUL_EN) begin
                e.due    = cyc + 1 + W;
                busy_cnt = W;
            end else begin
                e.due = cyc + 1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        execute = 1'b0;
        rst     = 1'b1;
        #1;
        check("reset_f", 32'(f), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ready", 32'(ready), 1);
        sb.delete();
        busy_cnt = 0;
        model_f  = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every done strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    mon_e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %s_missing_done actual=none required=done_at_cycle_%0d", mon_e.name, mon_e.due);
                    model_f = mon_e.val;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done actual=done f=%0d required=no_done", f);
                        model_f = 32'(f);
                    end else begin
                        mon_e = sb.pop_front();
                        check({mon_e.name, "_f"}, 32'(f), mon_e.val);
                        check({mon_e.name, "_latency"}, cyc, mon_e.due);
                        model_f = mon_e.val;
                    end
                end else begin
                    check("f_hold", 32'(f), model_f);
                end
            end
        end
    end

    initial begin
        do_reset();

        cycle(1'b1, 3'd1, 3'd5, 3'd6, "add_5_6");
        cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");
        cycle(1'b1, 3'd2, 3'd2, 3'd5, "sub_2_5");
        cycle(1'b1, 3'd7, 3'd3, 3'd4, "sgt_3_4");
        cycle(1'b1, 3'd7, 3'd4, 3'd3, "sgt_4_3");
        cycle(1'b1, 3'd5, 3'd5, 3'd3, "shl_5_3");
        cycle(1'b1, 3'd5, 3'd5, 3'd6, "shl_5_6");
        cycle(1'b1, 3'd4, 3'd6, 3'd1, "shr_6_1");
        cycle(1'b1, 3'd6, 3'd5, 3'd3, "xnor_5_3");
        cycle(1'b1, 3'd0, 3'd7, 3'd7, "nothing");
        cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");

        cycle(1'b1, 3'd3, 3'd7, 3'd7, "mul_7_7");
        repeat (3) cycle(1'b1, 3'd1, 3'd1, 3'd1, "add_during_mul");
        cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");
        cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");

        cycle(1'b1, 3'd3, 3'd5, 3'd3, "mul_5_3");
        repeat (3) cycle(1'b0, 3'd3, 3'd7, 3'd7, "idle");
        cycle(1'b1, 3'd1, 3'd7, 3'd7, "add_after_mul");
        cycle(1'b1, 3'd3, 3'd6, 3'd0, "mul_6_0");
        repeat (W) cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");

        cycle(1'b1, 3'd3, 3'd6, 3'd6, "mul_aborted");
        cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");
        do_reset();
        cycle(1'b1, 3'd3, 3'd6, 3'd5, "mul_6_5");
        repeat (W + 1) cycle(1'b0, 3'd0, 3'd0, 3'd0, "idle");

        repeat (400) begin
            cycle($urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)),
                  W'($urandom_range(0, (1 << W) - 1)),
                  W'($urandom_range(0, (1 << W) - 1)),
                  "rand");
        end

        repeat (W + 3) cycle(1'b0, 3'd0, 3'd0, 3'd0, "drain");
        @(negedge clk);
        #2;
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
